// File: rtl/fetch_address_sequencer.sv
// Walks a programmable window of memory addresses, one fetch request at a time,
// with optional continuous looping over the window and a sticky end-of-window flag.
module fetch_address_sequencer #(
  parameter int          ADDR_W = 32,
  parameter int unsigned STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              loop_en,
  input  logic              abort,
  input  logic              fetch_data_ready,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] fetch_index,
  output logic [ADDR_W-1:0] pass_count,
  output logic              busy,
  output logic              end_of_memory,
  output logic [1:0]        state_dbg
);

  // Handshake: fetch_req is the valid, fetch_data_ready the ready. A request is
  // accepted only on a cycle where both are high; address/index hold otherwise,
  // and ready seen while fetch_req is low carries no meaning.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STRIDE_W = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] ONE_W    = ADDR_W'(1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n, index_n, pass_n;
  logic              eom_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [ADDR_W-1:0] count_q, count_n;
  logic              loop_q, loop_n;
  logic              accept;
  logic              last_index;

  assign accept     = (state == S_FETCH) && fetch_data_ready;
  assign last_index = (fetch_index == (count_q - ONE_W));

  always_comb begin
    state_n = state;
    addr_n  = fetch_addr;
    index_n = fetch_index;
    pass_n  = pass_count;
    eom_n   = end_of_memory;
    base_n  = base_q;
    count_n = count_q;
    loop_n  = loop_q;

    // Abort has priority over both a pending accept and a start pulse.
    if (abort) begin
      state_n = S_IDLE;
      eom_n   = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_n  = base_addr;
            count_n = word_count;
            loop_n  = loop_en;
            index_n = '0;
            pass_n  = '0;
            eom_n   = 1'b0;
            if (word_count == '0) begin
              state_n = S_DONE;
              eom_n   = 1'b1;
            end else begin
              state_n = S_FETCH;
              addr_n  = base_addr;
            end
          end
        end
        S_FETCH: begin
          if (accept) begin
            if (!last_index) begin
              addr_n  = fetch_addr + STRIDE_W;
              index_n = fetch_index + ONE_W;
            end else if (loop_q) begin
              addr_n  = base_q;
              index_n = '0;
              pass_n  = pass_count + ONE_W;
            end else begin
              state_n = S_DONE;
              eom_n   = 1'b1;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      fetch_addr    <= '0;
      fetch_index   <= '0;
      pass_count    <= '0;
      end_of_memory <= 1'b0;
      base_q        <= '0;
      count_q       <= '0;
      loop_q        <= 1'b0;
    end else begin
      state         <= state_n;
      fetch_addr    <= addr_n;
      fetch_index   <= index_n;
      pass_count    <= pass_n;
      end_of_memory <= eom_n;
      base_q        <= base_n;
      count_q       <= count_n;
      loop_q        <= loop_n;
    end
  end

  assign fetch_req = (state == S_FETCH);
  assign busy      = (state == S_FETCH);
  assign state_dbg = state;

endmodule

// File: tb/tb_fetch_address_sequencer.sv
// Randomized scoreboard bench for fetch_address_sequencer: expected fetches are
// computed per pass from base/stride arithmetic and checked by a monitor.
module tb_fetch_address_sequencer;

  localparam int W      = 32;
  localparam int STRIDE = 1;
  localparam int EXP_W  = 3 * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] base_addr;
  logic [W-1:0] word_count;
  logic         loop_en;
  logic         abort;
  logic         fetch_data_ready;
  logic         fetch_req;
  logic [W-1:0] fetch_addr;
  logic [W-1:0] fetch_index;
  logic [W-1:0] pass_count;
  logic         busy;
  logic         end_of_memory;
  logic [1:0]   state_dbg;

  logic [EXP_W-1:0] exp_q[$];
  int n_vec   = 0;
  int n_err   = 0;
  int acc_cnt = 0;

  fetch_address_sequencer #(.ADDR_W(W), .STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .loop_en(loop_en), .abort(abort),
    .fetch_data_ready(fetch_data_ready), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_index(fetch_index),
    .pass_count(pass_count), .busy(busy), .end_of_memory(end_of_memory),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // reference model: the i-th accepted fetch since start sits at index i%count
  // of pass i/count, at base + index*STRIDE modulo 2^W
  task automatic push_pass(input logic [W-1:0] base, input logic [W-1:0] count, input int n);
    logic [W-1:0] idx, pass, addr;
    for (int i = 0; i < n; i++) begin
      idx  = W'(i % int'(count));
      pass = W'(i / int'(count));
      addr = base + idx * W'(STRIDE);
      exp_q.push_back({addr, idx, pass});
    end
  endtask

  // driver tasks
  task automatic start_pass(input logic [W-1:0] base, input logic [W-1:0] count, input logic loop);
    base_addr  = base;
    word_count = count;
    loop_en    = loop;
    acc_cnt    = 0;
    start      = 1'b1;
    cyc();
    start      = 1'b0;
    check("start_req", fetch_req, count != 0);
    check("start_eom", end_of_memory, count == 0);
    if (count != 0) check("start_addr", fetch_addr, base);
  endtask

  task automatic run_until(input int target, input int budget, input bit rand_ready);
    for (int n = 0; n < budget && acc_cnt < target; n++) begin
      if (rand_ready) fetch_data_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    check("accept_count", acc_cnt, target);
  endtask

  task automatic check_done(input string name);
    check(name, {fetch_req, busy, end_of_memory}, 3'b001);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_leftover();
    check("leftover", exp_q.size(), 1);
    exp_q.delete();
  endtask

  // scoreboard monitor: every presented request must match the head entry
  always @(negedge clk) begin
    if (rst && fetch_req) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_req: got addr %0h index %0h required no request", fetch_addr, fetch_index);
      end else begin
        check("fetch", {fetch_addr, fetch_index, pass_count}, exp_q[0]);
        check("fetch_flags", {busy, end_of_memory}, 2'b10);
        if (fetch_data_ready && !abort) begin
          void'(exp_q.pop_front());
          acc_cnt++;
        end
      end
    end
  end

  initial begin
    logic [W-1:0] b;
    logic [W-1:0] cnt;
    rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    loop_en = 1'b0; abort = 1'b0; fetch_data_ready = 1'b0;
    repeat (3) cyc();
    check("reset_outs", {fetch_req, busy, end_of_memory, fetch_addr, fetch_index, pass_count}, '0);
    rst = 1'b1;
    cyc();

    // full 186-word window, ready tied high
    fetch_data_ready = 1'b1;
    push_pass('0, 186, 186);
    start_pass('0, 186, 1'b0);
    run_until(186, 400, 1'b0);
    check_done("done_186");
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("done_hold", {fetch_req, end_of_memory}, 2'b01);
    end

    // address wrap with random ready
    fetch_data_ready = 1'b0;
    push_pass(32'hFFFF_FFFE, 4, 4);
    start_pass(32'hFFFF_FFFE, 4, 1'b0);
    run_until(4, 200, 1'b1);
    check_done("done_wrap");

    // random windows
    for (int r = 0; r < 4; r++) begin
      b   = $urandom;
      cnt = W'($urandom_range(1, 12));
      push_pass(b, cnt, int'(cnt));
      start_pass(b, cnt, 1'b0);
      run_until(int'(cnt), int'(cnt) * 20 + 20, 1'b1);
      check_done("done_rand");
    end

    // loop mode: 10 accepts over a 3-word window
    fetch_data_ready = 1'b1;
    push_pass(32'h100, 3, 11);
    start_pass(32'h100, 3, 1'b1);
    run_until(10, 20, 1'b0);
    fetch_data_ready = 1'b0;
    check("loop_pass", {pass_count, end_of_memory}, {32'd3, 1'b0});
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("loop_abort", {fetch_req, busy, end_of_memory}, 3'b000);
    check_leftover();

    // zero-count start, then a 2-word start clears the flag
    b = $urandom;
    start_pass(b, 0, 1'b0);
    repeat (3) cyc();
    check("zero_hold", {fetch_req, end_of_memory}, 2'b01);
    fetch_data_ready = 1'b1;
    push_pass(b, 2, 2);
    start_pass(b, 2, 1'b0);
    run_until(2, 20, 1'b0);
    check_done("done_two");

    // abort together with ready at index 5; start mid-pass is ignored
    b = $urandom;
    push_pass(b, 10, 6);
    start_pass(b, 10, 1'b0);
    run_until(2, 20, 1'b0);
    base_addr = ~b; word_count = 7; loop_en = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    run_until(5, 20, 1'b0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_flags", {fetch_req, busy, end_of_memory}, 3'b000);
    check("abort_hold", {fetch_addr, fetch_index, pass_count}, {b + 32'd5, 32'd5, 32'd0});
    cyc();
    check("abort_idle", fetch_req, 1'b0);
    check_leftover();

    // asynchronous reset mid-pass at index 50
    b = $urandom;
    push_pass(b, 100, 51);
    start_pass(b, 100, 1'b0);
    run_until(50, 100, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_async", {fetch_req, busy, end_of_memory, fetch_addr, fetch_index, pass_count}, '0);
    repeat (3) cyc();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("rst_no_resume", {fetch_req, busy}, 2'b00);
    end
    check_leftover();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_address_sequencer.md
# fetch_address_sequencer

Clocked, parametrised address sequencer for the memory fetch path: on a start pulse it walks a programmable window of memory addresses, presenting one fetch request at a time and advancing only when the memory side signals `fetch_data_ready`. It reports progress and a sticky `end_of_memory` flag, and can loop over the window continuously. It sits between the frame/control logic and the memory read port, ahead of the collision-detection datapath.

## Interface
- `ADDR_W`, 32, width of addresses and counts
- `STRIDE`, 1, address increment per accepted fetch (unsigned, < 2^ADDR_W)
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse; latches `base_addr`/`word_count`/`loop_en`
- `base_addr`  in  ADDR_W  first address of window
- `word_count`  in  ADDR_W  number of fetches per pass (e.g. 186)
- `loop_en`  in  1  1 = restart at `base_addr` after last fetch instead of finishing
- `abort`  in  1  synchronous cancel
- `fetch_data_ready`  in  1  memory accepted current request / data available
- `fetch_req`  out  1  request valid
- `fetch_addr`  out  ADDR_W  address of current request
- `fetch_index`  out  ADDR_W  0-based index of current request within pass
- `pass_count`  out  ADDR_W  completed passes since start (loop mode)
- `busy`  out  1  high in FETCH
- `end_of_memory`  out  1  sticky: window completed (non-loop)

## Operation
- States: IDLE, FETCH, DONE. Reset -> IDLE; all outputs 0.
- Accept = `fetch_req` & `fetch_data_ready` in same cycle. `fetch_data_ready` while `fetch_req`=0 is ignored.
- IDLE/DONE + `start`: latch config; `fetch_index`<=0, `pass_count`<=0, `end_of_memory`<=0; if `word_count`=0 -> DONE with `end_of_memory`<=1; else FETCH, `fetch_addr`<=`base_addr`.
- FETCH, accept, `fetch_index` < count-1: `fetch_addr`<=`fetch_addr`+STRIDE (mod 2^ADDR_W, wrap silently), `fetch_index`++.
- FETCH, accept on last index: loop_en latched=1 -> `fetch_addr`<=base, `fetch_index`<=0, `pass_count`++ (wraps), stay FETCH; loop_en=0 -> DONE, `end_of_memory`<=1, `fetch_req`<=0.
- `start` while in FETCH: ignored.
- `abort` (any state): next state IDLE, `fetch_req`/`busy`<=0, `end_of_memory`<=0; `fetch_addr`/`fetch_index`/`pass_count` hold. Abort beats accept and start in same cycle.
- DONE: outputs hold; `end_of_memory` stays 1 until `start`, `abort` or reset.
- `fetch_req` = `busy` = (state==FETCH), registered.
- Reset asserted mid-pass: immediate return to IDLE, all outputs 0; no request resumes after release without a new `start`.

## Timing
- `start` sampled at edge k -> `fetch_req`=1, `fetch_addr`=base at k+1.
- Accept at edge n -> new address/index visible after edge n; back-to-back accepts every cycle sustain 1 fetch/cycle.
- Final accept at edge n -> `end_of_memory`=1 and `fetch_req`=0 after edge n (same edge).
- `fetch_addr`, `fetch_index` stable while `fetch_req`=1 and no accept.
- Zero-count start at edge k -> `end_of_memory`=1 after k, `fetch_req` never asserts.

## Test plan
- Reset, base=0, count=186, loop_en=0, ready tied 1 -> 186 consecutive accepts, addresses 0..185, `end_of_memory`=1 the edge of the 186th accept, `fetch_req` drops, stays DONE 20 cycles.
- base=0xFFFF_FFFE, count=4, STRIDE=1, ready random 50% -> addresses FFFF_FFFE, FFFF_FFFF, 0, 1; each held until accepted; `fetch_index` 0..3.
- base=0x100, count=3, loop_en=1, ready=1 for 10 cycles -> addresses 100,101,102,100,... ; `pass_count` 1 after 3rd accept, 3 after 9th; `end_of_memory` never set.
- Start with count=0 -> no `fetch_req`, `end_of_memory`=1 one edge later; second start with count=2 clears it and runs 2 fetches.
- Abort asserted together with ready at index 5 -> no advance, IDLE next cycle, `fetch_addr` holds base+5, `end_of_memory`=0; start during FETCH has no effect.
- `rst` low mid-pass at index 50 -> all outputs 0 immediately (asynchronous); after release, no requests until new start.
